// File: rtl/chu_spi_slv_pkg.sv
// Shared constants for the SPI slave slot core: register offsets, status bit
// positions, synchronizer lane indices and the datapath state enum.
package chu_spi_slv_pkg;

  localparam logic [1:0] SPI_SLV_REG_RX   = 2'd0;
  localparam logic [1:0] SPI_SLV_REG_STAT = 2'd1;
  localparam logic [1:0] SPI_SLV_REG_TX   = 2'd2;
  localparam logic [1:0] SPI_SLV_REG_CTRL = 2'd3;

  localparam int STAT_RX_VALID   = 0;
  localparam int STAT_RX_OVERRUN = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_SS_ACTIVE  = 3;
  localparam int STAT_RX_FULL    = 4;

  localparam int SYNC_SCLK = 0;
  localparam int SYNC_SS_N = 1;
  localparam int SYNC_MOSI = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slv_state_e;

endpackage

// File: rtl/chu_spi_slave_core_if.sv
// FPro MMIO slot bus as seen by one slot core; the CPU side is the master.
interface chu_spi_slave_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_spi_slv_fifo.sv
// Small synchronous FIFO holding received SPI bytes; pop and push may coincide
// even when full, in which case occupancy is unchanged.
module chu_spi_slv_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/chu_spi_slave_core.sv
// SPI mode-0 peripheral slot core: oversampled pins, TX holding byte, RX store.
// Define SPI_SLV_RX_FIFO_EN to replace the single RX holding register with a FIFO.
module chu_spi_slave_core
  import chu_spi_slv_pkg::*;
#(
  parameter logic [7:0] DUMMY_BYTE        = 8'hFF,
  parameter int         RX_FIFO_DEPTH_BIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  chu_spi_slave_core_if.slave bus,
  input  logic                spi_sclk,
  input  logic                spi_ss_n,
  input  logic                spi_mosi,
  output logic                spi_miso
);
  localparam logic [2:0] SYNC_PRESET = 3'b010;

  logic [2:0] pin_raw, sync_new, sync_old;
  assign pin_raw = {spi_mosi, spi_ss_n, spi_sclk};

  // stage 0/1 form the synchronizer, stage 2 is the previous sample for edge detection
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [2:0] stage_q, stage_d;
      always_comb stage_d = {stage_q[1:0], pin_raw[gi]};
      always_ff @(posedge clk) begin
        if (!reset) stage_q <= {3{SYNC_PRESET[gi]}};
        else        stage_q <= stage_d;
      end
      assign sync_new[gi] = stage_q[1];
      assign sync_old[gi] = stage_q[2];
    end
  endgenerate

  logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
  logic ss_rise_q, ss_rise_d, ss_fall_q, ss_fall_d;
  logic mosi_bit;

  assign mosi_bit = sync_old[SYNC_MOSI];

  always_comb begin
    sclk_rise_d = sync_new[SYNC_SCLK] & ~sync_old[SYNC_SCLK];
    sclk_fall_d = ~sync_new[SYNC_SCLK] & sync_old[SYNC_SCLK];
    ss_rise_d   = sync_new[SYNC_SS_N] & ~sync_old[SYNC_SS_N];
    ss_fall_d   = ~sync_new[SYNC_SS_N] & sync_old[SYNC_SS_N];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
    end else begin
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      ss_rise_q   <= ss_rise_d;
      ss_fall_q   <= ss_fall_d;
    end
  end

  logic rd_pop, tx_wr, ctrl_clr;
  assign rd_pop   = bus.cs & bus.read  & (bus.addr[1:0] == SPI_SLV_REG_RX);
  assign tx_wr    = bus.cs & bus.write & (bus.addr[1:0] == SPI_SLV_REG_TX);
  assign ctrl_clr = bus.cs & bus.write & (bus.addr[1:0] == SPI_SLV_REG_CTRL) & bus.wr_data[0];

  spi_slv_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (ss_fall_q) state_d = ACTIVE;
      ACTIVE: if (ss_rise_q) state_d = IDLE;
    endcase
  end

  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d, rx_push_byte;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_empty_q, tx_empty_d, rx_overrun_q, rx_overrun_d;
  logic       rx_push, load_next, overrun_set;

  // A load samples the pre-write tx_buf, so a same-cycle CPU write survives as pending.
  always_comb begin
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    tx_buf_d     = tx_buf_q;
    tx_empty_d   = tx_empty_q;
    rx_push      = 1'b0;
    load_next    = 1'b0;
    rx_push_byte = {rx_shift_q[6:0], mosi_bit};
    if (state_q == IDLE) begin
      if (ss_fall_q) begin
        load_next = 1'b1;
        bit_cnt_d = 3'd0;
      end
    end else if (!ss_rise_q) begin
      if (sclk_rise_q) begin
        rx_shift_d = rx_push_byte;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_push    = (bit_cnt_q == 3'd7);
      end else if (sclk_fall_q) begin
        if (bit_cnt_q == 3'd0) load_next = 1'b1;
        else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end
    if (load_next) begin
      tx_shift_d = tx_empty_q ? DUMMY_BYTE : tx_buf_q;
      tx_empty_d = 1'b1;
    end
    if (tx_wr) begin
      tx_buf_d   = bus.wr_data[7:0];
      tx_empty_d = 1'b0;
    end
  end

  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (ctrl_clr)    rx_overrun_d = 1'b0;
    if (overrun_set) rx_overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      tx_buf_q     <= '0;
      tx_empty_q   <= 1'b1;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_buf_q     <= tx_buf_d;
      tx_empty_q   <= tx_empty_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  logic       rx_valid, rx_full;
  logic [7:0] rx_byte;

`ifdef SPI_SLV_RX_FIFO_EN
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  chu_spi_slv_fifo #(
    .DATA_W (8),
    .ADDR_W (RX_FIFO_DEPTH_BIT)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rd_pop),
    .din   (rx_push_byte),
    .dout  (fifo_dout),
    .full  (rx_full),
    .empty (fifo_empty)
  );

  assign rx_valid    = ~fifo_empty;
  assign rx_byte     = fifo_empty ? 8'h00 : fifo_dout;
  assign overrun_set = rx_push & rx_full & ~(rd_pop & ~fifo_empty);
`else
  localparam int unused_depth_bit = RX_FIFO_DEPTH_BIT;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;

  // A push that coincides with a pop replaces the byte being read out.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    if (rd_pop) rx_valid_d = 1'b0;
    if (rx_push && (!rx_valid_q || rd_pop)) begin
      rx_byte_d  = rx_push_byte;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_byte     = rx_byte_q;
  assign rx_full     = 1'b0;
  assign overrun_set = rx_push & rx_valid_q & ~rd_pop;
`endif

  logic [31:0] status;
  logic        unused_ok;
  assign unused_ok = ^{bus.addr[4:2], bus.wr_data[31:8], sync_new[SYNC_MOSI]};

  always_comb begin
    status                  = '0;
    status[STAT_RX_VALID]   = rx_valid;
    status[STAT_RX_OVERRUN] = rx_overrun_q;
    status[STAT_TX_EMPTY]   = tx_empty_q;
    status[STAT_SS_ACTIVE]  = (state_q == ACTIVE);
    status[STAT_RX_FULL]    = rx_full;
  end

  always_comb begin
    spi_miso    = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b1;
    bus.rd_data = '0;
    case (bus.addr[1:0])
      SPI_SLV_REG_RX:   bus.rd_data = {23'b0, rx_valid, rx_byte};
      SPI_SLV_REG_STAT: bus.rd_data = status;
      default:          bus.rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_chu_spi_slave_core.sv
// Directed bench for chu_spi_slave_core acting as an SPI mode-0 master and CPU;
// expected bus reads and MISO bytes go through scoreboard queues.
module tb_chu_spi_slave_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  miso_exp_q[$];

  chu_spi_slave_core_if bus_if ();

  chu_spi_slave_core #(
    .DUMMY_BYTE        (8'hFF),
    .RX_FIFO_DEPTH_BIT (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .spi_sclk (spi_sclk),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.write = 1'b1; bus_if.addr = {3'b0, a}; bus_if.wr_data = d;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.write = 1'b0;
    $display("bus wr reg%0d <= 0x%0h", a, d);
  endtask

  // expected value is pushed first, then popped when the read is performed
  task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    rd_exp_q.push_back(exp);
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.read = 1'b1; bus_if.addr = {3'b0, a};
    #1;
    e = rd_exp_q.pop_front();
    check(tag, bus_if.rd_data, e);
    $display("bus rd reg%0d -> 0x%0h (%s)", a, bus_if.rd_data, tag);
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.read = 1'b0;
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      half();
      spi_sclk = 1'b1;
      mi[i] = spi_miso;
      half();
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte_chk(input string tag, input logic [7:0] mo);
    logic [7:0] mi;
    logic [7:0] e;
    spi_bits(mo, 8, mi);
    e = miso_exp_q.pop_front();
    check(tag, {24'b0, mi}, {24'b0, e});
    $display("spi byte mosi=0x%0h miso=0x%0h (%s)", mo, mi, tag);
  endtask

  task automatic frame_end();
    half();
    spi_ss_n = 1'b1;
    half();
    half();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk;
    bus_if.cs = 1'b0; bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.addr = '0; bus_if.wr_data = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    expect_rd("rst_stat", 2'd1, 32'h4);
    expect_rd("rst_rx", 2'd0, 32'h0);
    expect_rd("rst_reg2", 2'd2, 32'h0);
    check("rst_miso", {31'b0, spi_miso}, 32'h1);

    // CPU byte returned while master sends 0x3C
    bus_write(2'd2, 32'h0000_00A5);
    expect_rd("t1_stat_txfull", 2'd1, 32'h0);
    miso_exp_q.push_back(8'hA5);
    spi_ss_n = 1'b0;
    half();
    expect_rd("t1_stat_active", 2'd1, 32'hC);
    spi_byte_chk("t1_miso", 8'h3C);
    frame_end();
    expect_rd("t1_rx_pop", 2'd0, 32'h13C);
    expect_rd("t1_rx_again", 2'd0, 32'h03C);
    expect_rd("t1_stat_end", 2'd1, 32'h4);

    // no pending TX byte: dummy shifted out
    miso_exp_q.push_back(8'hFF);
    spi_ss_n = 1'b0;
    spi_byte_chk("t2_miso_dummy", 8'h00);
    frame_end();
    expect_rd("t2_stat", 2'd1, 32'h5);
    expect_rd("t2_rx_pop", 2'd0, 32'h100);
    expect_rd("t2_stat_end", 2'd1, 32'h4);

    // two bytes in one frame without a CPU pop
    miso_exp_q.push_back(8'hFF);
    miso_exp_q.push_back(8'hFF);
    spi_ss_n = 1'b0;
    spi_byte_chk("t3_miso0", 8'h11);
    spi_byte_chk("t3_miso1", 8'h22);
    frame_end();
`ifdef SPI_SLV_RX_FIFO_EN
    expect_rd("t3_stat_fifo", 2'd1, 32'h5);
    expect_rd("t3_rx_pop0", 2'd0, 32'h111);
    expect_rd("t3_rx_pop1", 2'd0, 32'h122);
    expect_rd("t3_stat_end", 2'd1, 32'h4);
`else
    expect_rd("t3_stat_ovr", 2'd1, 32'h7);
    expect_rd("t3_rx_pop", 2'd0, 32'h111);
    expect_rd("t3_rx_again", 2'd0, 32'h011);
    expect_rd("t3_stat_popped", 2'd1, 32'h6);
    bus_write(2'd3, 32'h1);
    expect_rd("t3_stat_clr", 2'd1, 32'h4);
`endif

    // partial frame of 5 bits is discarded
    spi_ss_n = 1'b0;
    spi_bits(8'hFF, 5, junk);
    frame_end();
    expect_rd("t4_stat_partial", 2'd1, 32'h4);
    bus_write(2'd2, 32'h96);
    miso_exp_q.push_back(8'h96);
    spi_ss_n = 1'b0;
    spi_byte_chk("t4_miso", 8'h5A);
    frame_end();
    expect_rd("t4_rx_pop", 2'd0, 32'h15A);

    // reset pulled low during bit 4
    bus_write(2'd2, 32'h77);
    spi_ss_n = 1'b0;
    spi_bits(8'hA0, 3, junk);
    spi_mosi = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_rd("t5_rst_stat", 2'd1, 32'h4);
    check("t5_rst_miso", {31'b0, spi_miso}, 32'h1);
    expect_rd("t5_rst_rx", 2'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    spi_ss_n = 1'b1;
    half();
    half();
    expect_rd("t5_stat_after", 2'd1, 32'h4);
    bus_write(2'd2, 32'hE1);
    miso_exp_q.push_back(8'hE1);
    spi_ss_n = 1'b0;
    spi_byte_chk("t5_miso", 8'hC3);
    frame_end();
    expect_rd("t5_rx_pop", 2'd0, 32'h1C3);
    expect_rd("t5_stat_end", 2'd1, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
